// File: rtl/reg_pair_unit.sv
`default_nettype none
// ============================================================================
//  Module   : reg_pair_unit
//  Purpose  : A:B register pair for shift-and-add style datapaths. A loads
//             from a sum bus or clears. B loads an operand. The pair
//             right-shifts as one 2*WIDTH register. A shift counter tracks
//             progress. It raises Done after WIDTH shifts and flags extra
//             shift requests as a sticky Overrun.
//  Revision : 1.0  initial release
// ============================================================================
module reg_pair_unit #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr_a,
    input  logic             i_ld_a,
    input  logic             i_ld_b,
    input  logic             i_shift_en,
    input  logic             i_arith,
    input  logic             i_shift_in,
    input  logic [WIDTH-1:0] i_sum,
    input  logic [WIDTH-1:0] i_s,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic             o_b_out,
    output logic [CW-1:0]    o_shift_cnt,
    output logic             o_last,
    output logic             o_done,
    output logic             o_overrun
);

    // Counter values that mark the control states. IDLE is a count of 0,
    // SHIFTING is 1..WIDTH-1 and DONE is WIDTH. No separate state register is
    // kept, so the state and the counter can never disagree.
    localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_CNT_DONE = CW'(WIDTH);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_overrun;

    logic             w_done;
    logic             w_any_load;
    logic             w_shift;
    logic             w_overrun_set;
    logic             w_fill;

    // Status decodes of the shift counter.
    always_comb begin
        w_done = (r_cnt == C_CNT_DONE);
        o_last = (r_cnt == C_CNT_LAST);
    end

    // A load or clear on either register blocks the shift for the whole pair.
    // A pair that shifted only partly would corrupt the product alignment.
    always_comb begin
        w_any_load    = i_clr_a | i_ld_a | i_ld_b;
        w_shift       = i_shift_en & ~w_any_load & ~w_done;
        w_overrun_set = i_shift_en & ~w_any_load & w_done;
        w_fill        = i_arith ? r_a[WIDTH-1] : i_shift_in;
    end

    // Register A: the clear wins over the load, and the load wins over the shift.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a <= '0;
        end else if (i_clr_a) begin
            r_a <= '0;
        end else if (i_ld_a) begin
            r_a <= i_sum;
        end else if (w_shift) begin
            r_a <= {w_fill, r_a[WIDTH-1:1]};
        end
    end

    // Register B: the load wins over the shift. B takes the bit that drops out of A.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_b <= '0;
        end else if (i_ld_b) begin
            r_b <= i_s;
        end else if (w_shift) begin
            r_b <= {r_a[0], r_b[WIDTH-1:1]};
        end
    end

    // Shift counter: a new operand restarts it, and each taken shift advances it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_ld_b) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + C_CNT_ONE;
        end
    end

    // Sticky overrun: set by a shift request once Done is reached, and cleared only by a new operand.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun <= 1'b0;
        end else if (i_ld_b) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end
    end

    // Drive the outputs from the registers.
    always_comb begin
        o_a         = r_a;
        o_b         = r_b;
        o_b_out     = r_b[0];
        o_shift_cnt = r_cnt;
        o_done      = w_done;
        o_overrun   = r_overrun;
    end

endmodule
`default_nettype wire
